// File: rtl/parity_scheduler.sv
// Round-robin front end for a shared serial even-parity engine.
// The winner's word is latched and shifted out LSB-first, one bit per clock.
// The parity of the W bits is returned with a one-cycle done pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | wait for a request; the accepting edge grants and latches the word
// SHIFT | present shreg[0] on bit_out and fold it into the accumulator
// DONE  | word fully shifted; the edge leaving DONE publishes parity/done
module parity_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              done,
  output logic              parity,
  output logic [OW-1:0]     owner
);

  localparam int            CW      = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST    = CW'(W - 1);
  localparam logic [OW-1:0] PTR_RST = OW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [OW-1:0]  ptr, ptr_nxt;
  logic [W-1:0]   shreg, shreg_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           acc, acc_nxt;

  logic [NREQ-1:0] gnt_nxt;
  logic            busy_nxt;
  logic            bit_out_nxt;
  logic            bit_valid_nxt;
  logic            done_nxt;
  logic            parity_nxt;
  logic [OW-1:0]   owner_nxt;

  logic [W-1:0]    words [NREQ];
  logic [W-1:0]    word_sel;
  logic            found;
  logic [OW-1:0]   sel;

  // Split the flat data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      words[i] = data[i*W +: W];
    end
  end

  // Round-robin search: first pending request after the pointer, wrapping.
  always_comb begin
    int            j;
    logic [OW-1:0] cand;
    j     = 0;
    cand  = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end
      cand = OW'(j);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    word_sel = words[sel];
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and next values for every registered output and datapath register.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    shreg_nxt     = shreg;
    cnt_nxt       = cnt;
    acc_nxt       = acc;
    gnt_nxt       = '0;
    busy_nxt      = busy;
    bit_out_nxt   = 1'b0;
    bit_valid_nxt = 1'b0;
    done_nxt      = 1'b0;
    parity_nxt    = parity;
    owner_nxt     = owner;

    unique case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (found) begin
          state_nxt     = SHIFT;
          gnt_nxt       = NREQ'(1) << sel;
          shreg_nxt     = word_sel;
          owner_nxt     = sel;
          ptr_nxt       = sel;
          acc_nxt       = 1'b0;
          cnt_nxt       = '0;
          busy_nxt      = 1'b1;
          // The first bit is presented in the grant cycle itself.
          bit_valid_nxt = 1'b1;
          bit_out_nxt   = word_sel[0];
        end
      end

      SHIFT: begin
        busy_nxt  = 1'b1;
        acc_nxt   = acc ^ shreg[0];
        shreg_nxt = shreg >> 1;
        cnt_nxt   = cnt + CW'(1);
        if (cnt == LAST) begin
          state_nxt = DONE;
        end else begin
          // Registered bit_out must show the bit that will be at shreg[0] next cycle.
          bit_valid_nxt = 1'b1;
          bit_out_nxt   = shreg[1];
        end
      end

      DONE: begin
        state_nxt  = IDLE;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b1;
        parity_nxt = acc;
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= PTR_RST;
      shreg     <= '0;
      cnt       <= '0;
      acc       <= 1'b0;
      gnt       <= '0;
      busy      <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      done      <= 1'b0;
      parity    <= 1'b0;
      owner     <= '0;
    end else begin
      ptr       <= ptr_nxt;
      shreg     <= shreg_nxt;
      cnt       <= cnt_nxt;
      acc       <= acc_nxt;
      gnt       <= gnt_nxt;
      busy      <= busy_nxt;
      bit_out   <= bit_out_nxt;
      bit_valid <= bit_valid_nxt;
      done      <= done_nxt;
      parity    <= parity_nxt;
      owner     <= owner_nxt;
    end
  end

endmodule
